// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared encodings and CRC7 helper for the SD CMD line engine
//
// Contents: response-type and FSM state encodings, CRC7 polynomial,
// command frame length, and a single-step serial CRC7 function.

package sd_cmd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE        = 2'b00,
        RESP_SHORT       = 2'b01,
        RESP_LONG        = 2'b10,
        RESP_SHORT_NOCRC = 2'b11
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_RECV      = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam int         CMD_FRAME_BITS = 48;

    // One serial step of x^7 + x^3 + 1, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator (x^7 + x^3 + 1, seed 0)
//
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear to zero (wins over en_i)
//   en_i   - fold din_i into the CRC this edge
//   din_i  - serial data bit, MSB first
//   crc_o  - current CRC register value

module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, din_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_line_engine.sv
// rtl/sd_cmd_line_engine.sv - SD CMD-line framer/serialiser and response receiver
//
// Ports:
//   clk_SD, reset_host          - sole clock, async active-high reset
//   cmd_start/index/argument    - host request; captured when accepted in IDLE
//   resp_type                   - 00 none, 01 short checked, 10 long, 11 short unchecked
//   cmd_busy, cmd_done          - busy level and one-cycle completion pulse
//   response                    - received frame, MSB first, right-aligned
//   timeout/crc/index/end_bit_error - response status, held until next accept
//   cmd_pin_out, cmd_oe, cmd_pin_in - CMD pad interface

module sd_cmd_line_engine
    import sd_cmd_pkg::*;
#(
    parameter int SHORT_RESP_BITS = 48,
    parameter int LONG_RESP_BITS  = 136,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int NCC_CYCLES      = 8,
    parameter int CNT_W           = 8
) (
    input  logic                      clk_SD,
    input  logic                      reset_host,
    input  logic                      cmd_start,
    input  logic [5:0]                cmd_index,
    input  logic [31:0]               cmd_argument,
    input  logic [1:0]                resp_type,
    output logic                      cmd_busy,
    output logic                      cmd_done,
    output logic [LONG_RESP_BITS-1:0] response,
    output logic                      timeout_error,
    output logic                      crc_error,
    output logic                      index_error,
    output logic                      end_bit_error,
    output logic                      cmd_pin_out,
    output logic                      cmd_oe,
    input  logic                      cmd_pin_in
);

    if ((2 ** CNT_W) <= LONG_RESP_BITS || (2 ** CNT_W) <= TIMEOUT_CYCLES ||
        (2 ** CNT_W) <= NCC_CYCLES) begin : g_cnt_w_check
        $error("sd_cmd_line_engine: CNT_W too narrow for counters");
    end

    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(CMD_FRAME_BITS - 1);
    // Edge at which the TX CRC is complete and its MSB goes on the line.
    localparam logic [CNT_W-1:0] CRC_SWAP  = CNT_W'(CMD_FRAME_BITS - 9);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] NCC_LAST  = CNT_W'(NCC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CRC_LOW   = CNT_W'(8);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [46:0]               tx_sr_q, tx_sr_d;
    logic [5:0]                idx_q, idx_d;
    resp_type_e                rtype_q, rtype_d;
    logic [LONG_RESP_BITS-1:0] resp_q, resp_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      tmo_q, tmo_d;
    logic                      crc_err_q, crc_err_d;
    logic                      idx_err_q, idx_err_d;
    logic                      end_err_q, end_err_d;
    logic                      pin_q, pin_d;
    logic                      oe_q, oe_d;

    logic                      accept;
    logic [CNT_W-1:0]          resp_last;
    logic [CNT_W-1:0]          crc_top;
    logic [CNT_W-1:0]          rx_bit_idx;
    logic [LONG_RESP_BITS-1:0] resp_shift;
    logic                      tx_en, rx_en;
    logic [6:0]                tx_crc, rx_crc;

    assign accept     = (state_q == ST_IDLE) && cmd_start;
    assign resp_last  = (rtype_q == RESP_LONG) ? CNT_W'(LONG_RESP_BITS - 1)
                                               : CNT_W'(SHORT_RESP_BITS - 1);
    // Long responses exclude the 8-bit header from the CRC; short ones include it.
    assign crc_top    = (rtype_q == RESP_LONG) ? CNT_W'(LONG_RESP_BITS - 9)
                                               : CNT_W'(SHORT_RESP_BITS - 1);
    assign rx_bit_idx = resp_last - cnt_q;
    assign resp_shift = {resp_q[LONG_RESP_BITS-2:0], cmd_pin_in};

    // The start bit (0) is never fed: with seed 0 a leading zero leaves CRC7 unchanged.
    assign tx_en = (state_q == ST_SEND) && (cnt_q < CRC_SWAP);
    assign rx_en = (state_q == ST_RECV) && (rx_bit_idx >= CRC_LOW) && (rx_bit_idx <= crc_top);

    sd_crc7 u_tx_crc (
        .clk_i (clk_SD),
        .rst_i (reset_host),
        .clr_i (accept),
        .en_i  (tx_en),
        .din_i (tx_sr_q[46]),
        .crc_o (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clk_i (clk_SD),
        .rst_i (reset_host),
        .clr_i (accept),
        .en_i  (rx_en),
        .din_i (cmd_pin_in),
        .crc_o (rx_crc)
    );

    always_ff @(posedge clk_SD or posedge reset_host) begin
        if (reset_host) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (cmd_start) state_d = ST_SEND;
            ST_SEND:      if (cnt_q == SEND_LAST)
                              state_d = (rtype_q == RESP_NONE) ? ST_GAP : ST_WAIT_RESP;
            ST_WAIT_RESP: if (!cmd_pin_in) state_d = ST_RECV;
                          else if (cnt_q == TMO_LAST) state_d = ST_GAP;
            ST_RECV:      if (cnt_q == resp_last) state_d = ST_GAP;
            ST_GAP:       if (cnt_q == NCC_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        tx_sr_d   = tx_sr_q;
        idx_d     = idx_q;
        rtype_d   = rtype_q;
        resp_d    = resp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmo_d     = tmo_q;
        crc_err_d = crc_err_q;
        idx_err_d = idx_err_q;
        end_err_d = end_err_q;
        pin_d     = 1'b1;
        oe_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_d     = cmd_index;
                    rtype_d   = resp_type_e'(resp_type);
                    resp_d    = '0;
                    tmo_d     = 1'b0;
                    crc_err_d = 1'b0;
                    idx_err_d = 1'b0;
                    end_err_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    // Low byte is replaced by the CRC and end bit at CRC_SWAP.
                    tx_sr_d   = {1'b1, cmd_index, cmd_argument, 8'h01};
                    pin_d     = 1'b0;
                    oe_d      = 1'b1;
                end
            end
            ST_SEND: begin
                if (cnt_q == SEND_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    oe_d  = 1'b1;
                    if (cnt_q == CRC_SWAP) begin
                        pin_d   = tx_crc[6];
                        tx_sr_d = {tx_crc[5:0], 1'b1, 40'd0};
                    end else begin
                        pin_d   = tx_sr_q[46];
                        tx_sr_d = {tx_sr_q[45:0], 1'b0};
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (!cmd_pin_in) begin
                    resp_d = resp_shift;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECV: begin
                resp_d = resp_shift;
                if (cnt_q == resp_last) begin
                    cnt_d     = '0;
                    end_err_d = ~cmd_pin_in;
                    crc_err_d = (rtype_q != RESP_SHORT_NOCRC) && (rx_crc != resp_shift[7:1]);
                    idx_err_d = (rtype_q == RESP_SHORT) &&
                                (resp_shift[SHORT_RESP_BITS-3 -: 6] != idx_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == NCC_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_SD or posedge reset_host) begin
        if (reset_host) begin
            cnt_q     <= '0;
            tx_sr_q   <= '0;
            idx_q     <= '0;
            rtype_q   <= RESP_NONE;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            crc_err_q <= 1'b0;
            idx_err_q <= 1'b0;
            end_err_q <= 1'b0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tx_sr_q   <= tx_sr_d;
            idx_q     <= idx_d;
            rtype_q   <= rtype_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            crc_err_q <= crc_err_d;
            idx_err_q <= idx_err_d;
            end_err_q <= end_err_d;
            pin_q     <= pin_d;
            oe_q      <= oe_d;
        end
    end

    assign cmd_busy      = busy_q;
    assign cmd_done      = done_q;
    assign response      = resp_q;
    assign timeout_error = tmo_q;
    assign crc_error     = crc_err_q;
    assign index_error   = idx_err_q;
    assign end_bit_error = end_err_q;
    assign cmd_pin_out   = pin_q;
    assign cmd_oe        = oe_q;

endmodule
